sync_fifo_flags: RTL and testbench

Parametrised single-clock FIFO: the next-generation buffer for inter-block data paths in the sequential library. Adds a configurable read mode (registered or first-word-fall-through), true simultaneous read/write, occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It sits between a producer and a consumer in the same `clk` domain.

---
 rtl/fifo_pkg.sv | 8 +
 rtl/sync_fifo_flags_if.sv | 29 ++
 rtl/fifo_mem_2p.sv | 18 +
 rtl/sync_fifo_flags.sv | 73 +++++++
 tb/tb_sync_fifo_flags.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: read-mode constants and pointer/count width helper for the sync FIFO family
package fifo_pkg;
    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;
    function automatic int cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction
endpackage

// File: rtl/sync_fifo_flags_if.sv
// sync_fifo_flags_if: producer/consumer handshake, status and error bundle for sync_fifo_flags
interface sync_fifo_flags_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic                       wr_en;
    logic [DATA_W-1:0]          wr_data;
    logic                       rd_en;
    logic [DATA_W-1:0]          rd_data;
    logic                       rd_valid;
    logic                       full;
    logic                       empty;
    logic                       almost_full;
    logic                       almost_empty;
    logic [cnt_w(ADDR_W)-1:0]   count;
    logic                       overflow;
    logic                       underflow;
    logic                       clr_err;
    modport master (
        output wr_en, wr_data, rd_en, clr_err,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
    modport slave (
        input  wr_en, wr_data, rd_en, clr_err,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p: register array with synchronous write port and asynchronous read port
module fifo_mem_2p #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end
    assign rdata = mem_q[raddr];
endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with registered/FWFT read, occupancy flags and sticky errors
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 3,
    parameter int AF_THRESH = (2**ADDR_W) - 2,
    parameter int AE_THRESH = 1,
    parameter int FWFT      = FIFO_MODE_STD
) (
    input logic              clk,
    input logic              rst,
    sync_fifo_flags_if.slave bus
);
    localparam int CW = cnt_w(ADDR_W);
    localparam logic [CW-1:0] DEPTH_C = CW'(2**ADDR_W);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              wr_ok, rd_ok;
    logic [DATA_W-1:0] head;
    assign bus.full         = count_q == DEPTH_C;
    assign bus.empty        = count_q == '0;
    assign bus.almost_full  = count_q >= AF_C;
    assign bus.almost_empty = count_q <= AE_C;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
    assign wr_ok = bus.wr_en && !bus.full;
    assign rd_ok = bus.rd_en && !bus.empty;
    // error set takes priority over clr_err in the same cycle
    always_comb begin
        wr_ptr_d = rst ? '0 : wr_ptr_q + ADDR_W'(wr_ok);
        rd_ptr_d = rst ? '0 : rd_ptr_q + ADDR_W'(rd_ok);
        count_d  = rst ? '0 : (wr_ok && !rd_ok) ? count_q + CW'(1) : (rd_ok && !wr_ok) ? count_q - CW'(1) : count_q;
        ovf_d    = !rst && ((bus.wr_en && !wr_ok) || (ovf_q && !bus.clr_err));
        udf_d    = !rst && ((bus.rd_en && !rd_ok) || (udf_q && !bus.clr_err));
    end
    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        ovf_q    <= ovf_d;
        udf_q    <= udf_d;
    end
    fifo_mem_2p #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .we    (wr_ok && !rst),
        .waddr (wr_ptr_q),
        .wdata (bus.wr_data),
        .raddr (rd_ptr_q),
        .rdata (head)
    );
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign bus.rd_data  = head;
        assign bus.rd_valid = !bus.empty;
    end else begin : g_std
        logic [DATA_W-1:0] rd_data_q, rd_data_d;
        logic              rd_valid_q, rd_valid_d;
        always_comb begin
            rd_data_d  = rst ? '0 : rd_ok ? head : rd_data_q;
            rd_valid_d = !rst && rd_ok;
        end
        always_ff @(posedge clk) begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
        assign bus.rd_data  = rd_data_q;
        assign bus.rd_valid = rd_valid_q;
    end
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed checks of registered-read and FWFT instances of sync_fifo_flags
module tb_sync_fifo_flags;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  sync_fifo_flags_if #(.DATA_W(32), .ADDR_W(3)) a ();
  sync_fifo_flags_if #(.DATA_W(32), .ADDR_W(3)) b ();
  sync_fifo_flags #(.DATA_W(32), .ADDR_W(3), .AF_THRESH(6), .AE_THRESH(1), .FWFT(0)) u_std (.clk(clk), .rst(rst), .bus(a));
  sync_fifo_flags #(.DATA_W(32), .ADDR_W(3), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1)) u_fwft (.clk(clk), .rst(rst), .bus(b));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    #100000;
    $error("FAIL timeout: wait expired");
    $finish;
  end
  initial begin
    a.wr_en = 0; a.rd_en = 0; a.clr_err = 0; a.wr_data = '0;
    b.wr_en = 0; b.rd_en = 0; b.clr_err = 0; b.wr_data = '0;
    tick(); tick();
    rst = 0;
    chk("rst_count", a.count, 0);
    chk("rst_empty", a.empty, 1);
    chk("rst_full", a.full, 0);
    chk("rst_ae", a.almost_empty, 1);
    chk("rst_af", a.almost_full, 0);
    chk("rst_rd_valid", a.rd_valid, 0);
    chk("rst_rd_data", a.rd_data, 32'h0);
    chk("rst_ovf", a.overflow, 0);
    chk("rst_udf", a.underflow, 0);
    chk("rst_fwft_valid", b.rd_valid, 0);
    for (int i = 0; i < 8; i++) begin
      a.wr_en = 1; a.wr_data = 32'h10 + 32'(i);
      tick();
      chk("fill_count", a.count, i + 1);
      chk("fill_af", a.almost_full, (i + 1) >= 6);
      chk("fill_ae", a.almost_empty, (i + 1) <= 1);
    end
    a.wr_en = 0;
    chk("fill_full", a.full, 1);
    for (int i = 0; i < 8; i++) begin
      a.rd_en = 1;
      tick();
      chk("drain_valid", a.rd_valid, 1);
      chk("drain_data", a.rd_data, 32'h10 + 32'(i));
      chk("drain_count", a.count, 7 - i);
    end
    a.rd_en = 0;
    tick();
    chk("drain_valid_pulse", a.rd_valid, 0);
    chk("drain_hold", a.rd_data, 32'h17);
    chk("drain_empty", a.empty, 1);
    for (int i = 0; i < 4; i++) begin
      a.wr_en = 1; a.wr_data = 32'h20 + 32'(i);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      a.wr_en = 1; a.rd_en = 1; a.wr_data = 32'h24 + 32'(i);
      tick();
      chk("simul_count", a.count, 4);
      chk("simul_data", a.rd_data, 32'h20 + 32'(i));
    end
    a.wr_en = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("simul_tail", a.rd_data, 32'h34 + 32'(i));
    end
    a.rd_en = 0;
    chk("simul_empty", a.empty, 1);
    for (int i = 0; i < 8; i++) begin
      a.wr_en = 1; a.wr_data = 32'h40 + 32'(i);
      tick();
    end
    chk("coll_full", a.full, 1);
    a.wr_en = 1; a.rd_en = 1; a.wr_data = 32'hEE;
    tick();
    a.wr_en = 0;
    chk("coll_full_count", a.count, 7);
    chk("coll_full_ovf", a.overflow, 1);
    chk("coll_full_data", a.rd_data, 32'h40);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("coll_drain", a.rd_data, 32'h41 + 32'(i));
    end
    a.rd_en = 0; a.clr_err = 1;
    tick();
    a.clr_err = 0;
    chk("clr_ovf", a.overflow, 0);
    chk("coll_udf_quiet", a.underflow, 0);
    a.wr_en = 1; a.rd_en = 1; a.wr_data = 32'h55;
    tick();
    a.wr_en = 0;
    chk("coll_empty_count", a.count, 1);
    chk("coll_empty_udf", a.underflow, 1);
    chk("coll_empty_valid", a.rd_valid, 0);
    tick();
    chk("coll_empty_data", a.rd_data, 32'h55);
    chk("udf_sticky", a.underflow, 1);
    a.clr_err = 1;
    tick();
    chk("set_beats_clr", a.underflow, 1);
    a.rd_en = 0;
    tick();
    a.clr_err = 0;
    chk("clr_udf", a.underflow, 0);
    b.wr_en = 1; b.wr_data = 32'hA5;
    tick();
    b.wr_en = 0;
    chk("fwft_valid", b.rd_valid, 1);
    chk("fwft_data", b.rd_data, 32'hA5);
    chk("fwft_count", b.count, 1);
    tick();
    chk("fwft_hold", b.rd_data, 32'hA5);
    b.rd_en = 1;
    tick();
    b.rd_en = 0;
    chk("fwft_pop_valid", b.rd_valid, 0);
    chk("fwft_pop_empty", b.empty, 1);
    a.rd_en = 1;
    tick();
    a.rd_en = 0;
    for (int i = 0; i < 6; i++) begin
      a.wr_en = 1; a.wr_data = 32'h60 + 32'(i);
      tick();
    end
    a.wr_en = 0; a.rd_en = 1;
    tick();
    a.rd_en = 0;
    chk("pre_rst_count", a.count, 5);
    chk("pre_rst_udf", a.underflow, 1);
    chk("pre_rst_data", a.rd_data, 32'h60);
    rst = 1; a.wr_en = 1; a.wr_data = 32'hBAD;
    tick();
    rst = 0; a.wr_en = 0;
    chk("mid_rst_count", a.count, 0);
    chk("mid_rst_empty", a.empty, 1);
    chk("mid_rst_ae", a.almost_empty, 1);
    chk("mid_rst_af", a.almost_full, 0);
    chk("mid_rst_full", a.full, 0);
    chk("mid_rst_data", a.rd_data, 32'h0);
    chk("mid_rst_valid", a.rd_valid, 0);
    chk("mid_rst_udf", a.underflow, 0);
    chk("mid_rst_ovf", a.overflow, 0);
    a.wr_en = 1; a.wr_data = 32'h99;
    tick();
    a.wr_en = 0; a.rd_en = 1;
    tick();
    a.rd_en = 0;
    chk("post_rst_data", a.rd_data, 32'h99);
    chk("post_rst_valid", a.rd_valid, 1);
    chk("post_rst_count", a.count, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
